// File: rtl/fifo_wptr_ctrl_if.sv
// Write-side bus of the async FIFO pointer controller: producer request, read-domain
// pointer input, and the memory strobe / flags / occupancy returned by the controller.
interface fifo_wptr_ctrl_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 winc;
    logic [ADDR_SIZE:0]   rptr_gray;
    logic                 wen;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr_gray;
    logic                 wfull;
    logic                 walmost_full;
    logic [ADDR_SIZE:0]   wcount;
    logic                 woverflow;

    modport master (
        output winc, rptr_gray,
        input  wen, waddr, wptr_gray, wfull, walmost_full, wcount, woverflow
    );

    modport slave (
        input  winc, rptr_gray,
        output wen, waddr, wptr_gray, wfull, walmost_full, wcount, woverflow
    );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer controller for an async FIFO: binary/Gray write pointer,
// 2-FF synchronized read pointer, full / almost-full flags, occupancy and overflow.
module fifo_wptr_ctrl #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic           wclk,
    input  logic           wrst_n,
    fifo_wptr_ctrl_if.slave bus
);
    localparam int A = ADDR_SIZE;
    localparam logic [A:0] AFULL_T = AFULL_THRESH[A:0];

    logic [A:0] wbin;
    logic [A:0] wgray;
    logic [A:0] rq1;
    logic [A:0] rq2;
    logic [A:0] rbin_s;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] wcount_next;
    logic       full_next;
    logic       wfull_q;
    logic       wafull_q;
    logic [A:0] wcount_q;
    logic       wovf_q;
    logic       wen_c;

    assign wen_c = bus.winc & ~wfull_q;

    // NOTE: every variable driven here gets a value on every pass, so no latch is inferred.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= A; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
    end

    always_comb begin
        wbin_next   = wbin + {{A{1'b0}}, wen_c};
        wgray_next  = (wbin_next >> 1) ^ wbin_next;
        // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
        full_next   = (wgray_next == {~rq2[A:A-1], rq2[A-2:0]});
        wcount_next = wbin_next - rbin_s;
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin     <= '0;
            wgray    <= '0;
            rq1      <= '0;
            rq2      <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wcount_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            rq1      <= bus.rptr_gray;
            rq2      <= rq1;
            wbin     <= wbin_next;
            wgray    <= wgray_next;
            wfull_q  <= full_next;
            wafull_q <= (wcount_next >= AFULL_T);
            wcount_q <= wcount_next;
            wovf_q   <= wovf_q | (bus.winc & wfull_q);
        end
    end

    // The Gray pointer leaves straight from its register so the read domain never sees a glitch.
    assign bus.wen          = wen_c;
    assign bus.waddr        = wbin[A-1:0];
    assign bus.wptr_gray    = wgray;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = wafull_q;
    assign bus.wcount       = wcount_q;
    assign bus.woverflow    = wovf_q;
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl (ADDR_SIZE=4, AFULL_THRESH=12) with hand-computed
// expectations; inputs change 1 ns after a rising edge and outputs are checked there.
module tb_fifo_wptr_ctrl;
    logic wclk = 1'b0;
    logic wrst_n;
    int   tests = 0;
    int   fails = 0;

    fifo_wptr_ctrl_if #(.ADDR_SIZE(4)) bus ();

    fifo_wptr_ctrl #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .bus   (bus.slave)
    );

    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic do_reset();
        wrst_n        = 1'b0;
        bus.winc      = 1'b0;
        bus.rptr_gray = '0;
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n        = 1'b0;
        bus.winc      = 1'b1;
        bus.rptr_gray = '0;
        tick();
        tick();
        tests++; if (bus.wcount !== 5'd0) begin fails++; $display("FAIL reset_wcount got=%0d exp=0", bus.wcount); end
        tests++; if (bus.wptr_gray !== 5'b00000) begin fails++; $display("FAIL reset_wptr_gray got=%b exp=00000", bus.wptr_gray); end
        tests++; if (bus.waddr !== 4'd0) begin fails++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
        tests++; if (bus.wfull !== 1'b0) begin fails++; $display("FAIL reset_wfull got=%b exp=0", bus.wfull); end
        tests++; if (bus.walmost_full !== 1'b0) begin fails++; $display("FAIL reset_walmost_full got=%b exp=0", bus.walmost_full); end
        tests++; if (bus.woverflow !== 1'b0) begin fails++; $display("FAIL reset_woverflow got=%b exp=0", bus.woverflow); end
        bus.winc = 1'b0;
        #1;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL reset_wen got=%b exp=0", bus.wen); end
        wrst_n = 1'b1;
        tick();
        tests++; if (bus.wcount !== 5'd0) begin fails++; $display("FAIL reset_release_wcount got=%0d exp=0", bus.wcount); end
    endtask

    task automatic test_fill();
        bus.rptr_gray = '0;
        for (int i = 1; i <= 16; i++) begin
            bus.winc = 1'b1;
            #1;
            tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL fill_wen[%0d] got=%b exp=1", i, bus.wen); end
            tests++; if (bus.waddr !== 4'(i - 1)) begin fails++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, bus.waddr, i - 1); end
            tick();
            tests++; if (bus.wcount !== 5'(i)) begin fails++; $display("FAIL fill_wcount[%0d] got=%0d exp=%0d", i, bus.wcount, i); end
            tests++; if (bus.walmost_full !== (i >= 12)) begin fails++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, bus.walmost_full, i >= 12); end
            tests++; if (bus.wfull !== (i == 16)) begin fails++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, bus.wfull, i == 16); end
        end
        bus.winc = 1'b0;
        tests++; if (bus.wptr_gray !== 5'b11000) begin fails++; $display("FAIL fill_wptr_gray got=%b exp=11000", bus.wptr_gray); end
        tests++; if (bus.waddr !== 4'd0) begin fails++; $display("FAIL fill_waddr_end got=%0d exp=0", bus.waddr); end
    endtask

    task automatic test_overflow();
        tests++; if (bus.woverflow !== 1'b0) begin fails++; $display("FAIL ovf_pre got=%b exp=0", bus.woverflow); end
        for (int i = 0; i < 3; i++) begin
            bus.winc = 1'b1;
            #1;
            tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL ovf_wen[%0d] got=%b exp=0", i, bus.wen); end
            tick();
            tests++; if (bus.waddr !== 4'd0) begin fails++; $display("FAIL ovf_waddr[%0d] got=%0d exp=0", i, bus.waddr); end
            tests++; if (bus.wptr_gray !== 5'b11000) begin fails++; $display("FAIL ovf_wptr_gray[%0d] got=%b exp=11000", i, bus.wptr_gray); end
            tests++; if (bus.wcount !== 5'd16) begin fails++; $display("FAIL ovf_wcount[%0d] got=%0d exp=16", i, bus.wcount); end
            tests++; if (bus.woverflow !== 1'b1) begin fails++; $display("FAIL ovf_flag[%0d] got=%b exp=1", i, bus.woverflow); end
        end
        bus.winc = 1'b0;
        tick();
        tick();
        tests++; if (bus.woverflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", bus.woverflow); end
    endtask

    task automatic test_release_latency();
        bus.rptr_gray = 5'b00001;
        tick();  // edge k
        tests++; if (bus.wfull !== 1'b1) begin fails++; $display("FAIL rel_wfull_k got=%b exp=1", bus.wfull); end
        tick();  // edge k+1
        tests++; if (bus.wfull !== 1'b1) begin fails++; $display("FAIL rel_wfull_k1 got=%b exp=1", bus.wfull); end
        tests++; if (bus.wcount !== 5'd16) begin fails++; $display("FAIL rel_wcount_k1 got=%0d exp=16", bus.wcount); end
        tick();  // edge k+2
        tests++; if (bus.wfull !== 1'b0) begin fails++; $display("FAIL rel_wfull_k2 got=%b exp=0", bus.wfull); end
        tests++; if (bus.wcount !== 5'd15) begin fails++; $display("FAIL rel_wcount_k2 got=%0d exp=15", bus.wcount); end
        tests++; if (bus.walmost_full !== 1'b1) begin fails++; $display("FAIL rel_afull_k2 got=%b exp=1", bus.walmost_full); end
        tests++; if (bus.woverflow !== 1'b1) begin fails++; $display("FAIL rel_woverflow got=%b exp=1", bus.woverflow); end
    endtask

    // Reader pointer driven after edge j is (writes so far - 1), so each write leaves the
    // count 4 edges after it was accepted and occupancy peaks at 4.
    task automatic test_wrap();
        int r_drv [0:63];
        int w;
        int exp_cnt;
        do_reset();
        tests++; if (bus.woverflow !== 1'b0) begin fails++; $display("FAIL wrap_ovf_cleared got=%b exp=0", bus.woverflow); end
        for (int j = 0; j < 46; j++) begin
            bus.winc = (j < 40);
            tick();
            w = (j + 1 < 40) ? j + 1 : 40;
            r_drv[j] = (w > 0) ? w - 1 : 0;
            bus.rptr_gray = gray(r_drv[j]);
            exp_cnt = w - ((j >= 3) ? r_drv[j - 3] : 0);
            tests++; if (bus.wcount !== 5'(exp_cnt)) begin fails++; $display("FAIL wrap_wcount[%0d] got=%0d exp=%0d", j, bus.wcount, exp_cnt); end
            tests++; if (bus.wfull !== 1'b0) begin fails++; $display("FAIL wrap_wfull[%0d] got=%b exp=0", j, bus.wfull); end
            tests++; if (bus.waddr !== 4'(w % 16)) begin fails++; $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", j, bus.waddr, w % 16); end
            if (w == 31 && j == 30) begin
                tests++; if (bus.wptr_gray !== 5'b10000) begin fails++; $display("FAIL wrap_gray31 got=%b exp=10000", bus.wptr_gray); end
            end
            if (w == 32 && j == 31) begin
                tests++; if (bus.wptr_gray !== 5'b00000) begin fails++; $display("FAIL wrap_gray32 got=%b exp=00000", bus.wptr_gray); end
            end
        end
        bus.winc = 1'b0;
        tests++; if (bus.wptr_gray !== 5'b01100) begin fails++; $display("FAIL wrap_gray_end got=%b exp=01100", bus.wptr_gray); end
        tests++; if (bus.woverflow !== 1'b0) begin fails++; $display("FAIL wrap_woverflow got=%b exp=0", bus.woverflow); end
        tests++; if (bus.wcount !== 5'd1) begin fails++; $display("FAIL wrap_wcount_end got=%0d exp=1", bus.wcount); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.winc = 1'b1;
            tick();
        end
        tests++; if (bus.wcount !== 5'd9) begin fails++; $display("FAIL mid_pre_wcount got=%0d exp=9", bus.wcount); end
        wrst_n   = 1'b0;
        bus.winc = 1'b1;
        tick();
        tests++; if (bus.wcount !== 5'd0) begin fails++; $display("FAIL mid_wcount got=%0d exp=0", bus.wcount); end
        tests++; if (bus.wfull !== 1'b0) begin fails++; $display("FAIL mid_wfull got=%b exp=0", bus.wfull); end
        tests++; if (bus.wptr_gray !== 5'b00000) begin fails++; $display("FAIL mid_wptr_gray got=%b exp=00000", bus.wptr_gray); end
        tests++; if (bus.waddr !== 4'd0) begin fails++; $display("FAIL mid_waddr got=%0d exp=0", bus.waddr); end
        wrst_n   = 1'b1;
        bus.winc = 1'b0;
        tick();
        tests++; if (bus.wcount !== 5'd0) begin fails++; $display("FAIL mid_post_wcount got=%0d exp=0", bus.wcount); end
        tests++; if (bus.wptr_gray !== 5'b00000) begin fails++; $display("FAIL mid_post_gray got=%b exp=00000", bus.wptr_gray); end
    endtask

    initial begin
        wrst_n        = 1'b0;
        bus.winc      = 1'b0;
        bus.rptr_gray = '0;
        #2;
        test_reset();
        test_fill();
        test_overflow();
        test_release_latency();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
